// File: rtl/scan_frame_sched_pkg.sv
// Shared definitions for the scan frame scheduler.
// FSM encoding and board-level defaults.
package scan_frame_sched_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        S_HDR = 3'd1,
        S_LO  = 3'd2,
        S_HI  = 3'd3,
        S_SUM = 3'd4
    } state_t;

    localparam logic [7:0] DEF_HDR_BYTE = 8'hA5;
    localparam int         DEF_TICK_DIV = 12500000;

endpackage

// File: rtl/scan_frame_sched_if.sv
// Byte handshake toward the UART transmitter.
// The master offers bytes, the slave accepts them.
interface scan_frame_sched_if;

    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready;

    modport master (
        output tx_valid,
        output tx_data,
        input  tx_ready
    );

    modport slave (
        input  tx_valid,
        input  tx_data,
        output tx_ready
    );

endinterface

// File: rtl/scan_tick_gen.sv
// Enable-gated scan period divider.
// Emits a registered one-cycle tick once per TICK_DIV cycles.
module scan_tick_gen #(
    parameter int TICK_DIV = 12500000
) (
    input  logic clk_in,
    input  logic reset,
    input  logic enable,
    output logic tick
);

    localparam int CW = $clog2(TICK_DIV);

    logic [CW-1:0] cnt;
    logic          at_max;

    assign at_max = (cnt == CW'(TICK_DIV - 1));

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (!enable) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else begin
            cnt  <= at_max ? '0 : cnt + 1'b1;
            tick <= at_max;
        end
    end

endmodule

// File: rtl/scan_frame_sched.sv
// Periodic 16-bit input scanner that ships each snapshot
// as a 4-byte frame: header, low, high, checksum.
module scan_frame_sched
    import scan_frame_sched_pkg::*;
#(
    parameter int         TICK_DIV = DEF_TICK_DIV,
    parameter logic [7:0] HDR_BYTE = DEF_HDR_BYTE
) (
    input  logic          clk_in,
    input  logic          reset,
    input  logic          enable,
    input  logic [16:1]   in,
    scan_frame_sched_if.master tx,
    output logic          frame_start,
    output logic          busy,
    output logic [7:0]    overrun_cnt
);

    state_t      state;
    logic        tick;
    logic        valid_q;
    logic [7:0]  data_q;
    logic [16:1] sync1;
    logic [16:1] sync2;
    logic [16:1] snap;
    logic        xfer;

    scan_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk_in (clk_in),
        .reset  (reset),
        .enable (enable),
        .tick   (tick)
    );

    assign tx.tx_valid = valid_q;
    assign tx.tx_data  = data_q;
    assign xfer        = valid_q & tx.tx_ready;

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            valid_q     <= 1'b0;
            data_q      <= 8'h00;
            frame_start <= 1'b0;
            busy        <= 1'b0;
            overrun_cnt <= 8'h00;
            sync1       <= '0;
            sync2       <= '0;
            snap        <= '0;
        end else begin
            sync1       <= in;
            sync2       <= sync1;
            frame_start <= 1'b0;
            // a tick that lands while a frame is in flight is dropped
            if (tick && state != IDLE && overrun_cnt != 8'hFF)
                overrun_cnt <= overrun_cnt + 8'd1;
            unique case (state)
                IDLE: if (tick) begin
                    snap        <= sync2;
                    state       <= S_HDR;
                    frame_start <= 1'b1;
                    busy        <= 1'b1;
                    valid_q     <= 1'b1;
                    data_q      <= HDR_BYTE;
                end
                S_HDR: if (xfer) begin
                    state  <= S_LO;
                    data_q <= snap[8:1];
                end
                S_LO: if (xfer) begin
                    state  <= S_HI;
                    data_q <= snap[16:9];
                end
                S_HI: if (xfer) begin
                    state  <= S_SUM;
                    data_q <= HDR_BYTE ^ snap[8:1] ^ snap[16:9];
                end
                S_SUM: if (xfer) begin
                    state   <= IDLE;
                    valid_q <= 1'b0;
                    busy    <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_scan_frame_sched.sv
// Directed bench for scan_frame_sched with TICK_DIV=8.
// Frame vectors from a table plus stall, overrun and reset sequences.
module tb_scan_frame_sched;

    logic        clk_in;
    logic        reset;
    logic        enable;
    logic [16:1] in;
    logic        frame_start;
    logic        busy;
    logic [7:0]  overrun_cnt;

    scan_frame_sched_if u_if ();

    scan_frame_sched #(
        .TICK_DIV (8),
        .HDR_BYTE (8'hA5)
    ) dut (
        .clk_in      (clk_in),
        .reset       (reset),
        .enable      (enable),
        .in          (in),
        .tx          (u_if.master),
        .frame_start (frame_start),
        .busy        (busy),
        .overrun_cnt (overrun_cnt)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [15:0]     din;
        logic [3:0][7:0] b;
    } vec_t;

    vec_t vecs[6];
    int   n_tests;
    int   n_fail;

    task automatic chk(input string name, input logic [15:0] act,
                       input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk_in);
    endtask

    task automatic do_reset();
        reset          = 1'b0;
        enable         = 1'b0;
        u_if.tx_ready  = 1'b0;
        repeat (3) step();
        reset = 1'b1;
        step();
    endtask

    // waits for frame_start on a negedge; timeout counts as failure
    task automatic wait_fs(input string name, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (frame_start) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk({name, "_fs_timeout"}, 16'd0, 16'd1);
    endtask

    task automatic chk_frame(input string name, input logic [3:0][7:0] b);
        chk({name, "_hdr_valid"}, 16'(u_if.tx_valid), 16'd1);
        chk({name, "_hdr"}, 16'(u_if.tx_data), 16'(b[0]));
        for (int k = 1; k < 4; k++) begin
            step();
            chk($sformatf("%s_b%0d_valid", name, k), 16'(u_if.tx_valid), 16'd1);
            chk($sformatf("%s_b%0d", name, k), 16'(u_if.tx_data), 16'(b[k]));
        end
    endtask

    initial begin
        bit ok;
        int gap;
        bit seen_v;
        bit seen_fs;
        n_tests = 0;
        n_fail  = 0;
        in      = 16'h0000;

        vecs[0] = '{din: 16'h12F0, b: {8'h47, 8'h12, 8'hF0, 8'hA5}};
        vecs[1] = '{din: 16'h0000, b: {8'hA5, 8'h00, 8'h00, 8'hA5}};
        vecs[2] = '{din: 16'hFFFF, b: {8'hA5, 8'hFF, 8'hFF, 8'hA5}};
        vecs[3] = '{din: 16'h0001, b: {8'hA4, 8'h00, 8'h01, 8'hA5}};
        vecs[4] = '{din: 16'h8000, b: {8'h25, 8'h80, 8'h00, 8'hA5}};
        vecs[5] = '{din: 16'hA55A, b: {8'h5A, 8'hA5, 8'h5A, 8'hA5}};

        // reset values while reset is held
        reset         = 1'b0;
        enable        = 1'b0;
        u_if.tx_ready = 1'b0;
        repeat (2) step();
        chk("rst_valid", 16'(u_if.tx_valid), 16'd0);
        chk("rst_data", 16'(u_if.tx_data), 16'h00);
        chk("rst_fs", 16'(frame_start), 16'd0);
        chk("rst_busy", 16'(busy), 16'd0);
        chk("rst_ovr", 16'(overrun_cnt), 16'd0);

        // enable low: nothing happens for 100 cycles
        reset   = 1'b1;
        seen_v  = 1'b0;
        seen_fs = 1'b0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (u_if.tx_valid) seen_v = 1'b1;
            if (frame_start) seen_fs = 1'b1;
        end
        chk("idle_valid", 16'(seen_v), 16'd0);
        chk("idle_fs", 16'(seen_fs), 16'd0);
        chk("idle_ovr", 16'(overrun_cnt), 16'd0);

        // table-driven frames with tx_ready held high
        foreach (vecs[v]) begin
            do_reset();
            in            = vecs[v].din;
            u_if.tx_ready = 1'b1;
            enable        = 1'b1;
            wait_fs($sformatf("v%0d", v), ok);
            if (ok) begin
                chk_frame($sformatf("v%0d", v), vecs[v].b);
                step();
                chk($sformatf("v%0d_end_valid", v), 16'(u_if.tx_valid), 16'd0);
                chk($sformatf("v%0d_end_busy", v), 16'(busy), 16'd0);
                gap = 4;
                while (!frame_start && gap < 30) begin
                    step();
                    gap++;
                end
                chk($sformatf("v%0d_period", v), 16'(gap), 16'd8);
                chk($sformatf("v%0d_ovr", v), 16'(overrun_cnt), 16'd0);
            end
        end

        // stall 5 cycles while the low byte is offered
        do_reset();
        in            = 16'h12F0;
        u_if.tx_ready = 1'b1;
        enable        = 1'b1;
        wait_fs("stall", ok);
        if (ok) begin
            chk("stall_hdr", 16'(u_if.tx_data), 16'hA5);
            step();
            chk("stall_lo", 16'(u_if.tx_data), 16'hF0);
            u_if.tx_ready = 1'b0;
            for (int i = 0; i < 5; i++) begin
                step();
                chk($sformatf("stall_hold_v%0d", i), 16'(u_if.tx_valid), 16'd1);
                chk($sformatf("stall_hold_d%0d", i), 16'(u_if.tx_data), 16'hF0);
            end
            u_if.tx_ready = 1'b1;
            step();
            chk("stall_hi", 16'(u_if.tx_data), 16'h12);
            step();
            chk("stall_sum", 16'(u_if.tx_data), 16'h47);
            step();
            chk("stall_end", 16'(u_if.tx_valid), 16'd0);
        end

        // header held 40 cycles: ticks are dropped, frame still completes
        do_reset();
        in            = 16'h12F0;
        u_if.tx_ready = 1'b0;
        enable        = 1'b1;
        wait_fs("ovr", ok);
        if (ok) begin
            repeat (40) step();
            chk("ovr_range", 16'(overrun_cnt == 8'd4 || overrun_cnt == 8'd5), 16'd1);
            chk("ovr_busy", 16'(busy), 16'd1);
            u_if.tx_ready = 1'b1;
            chk_frame("ovr", vecs[0].b);
        end

        // long stall saturates the counter
        do_reset();
        in            = 16'h0F0F;
        u_if.tx_ready = 1'b0;
        enable        = 1'b1;
        repeat (2100) step();
        chk("sat_255", 16'(overrun_cnt), 16'hFF);
        repeat (100) step();
        chk("sat_hold", 16'(overrun_cnt), 16'hFF);
        chk("sat_data", 16'(u_if.tx_data), 16'hA5);

        // asynchronous reset while the high byte is offered
        do_reset();
        in            = 16'h12F0;
        u_if.tx_ready = 1'b1;
        enable        = 1'b1;
        wait_fs("mrst", ok);
        if (ok) begin
            step();
            step();
            chk("mrst_hi", 16'(u_if.tx_data), 16'h12);
            u_if.tx_ready = 1'b0;
            #1 reset = 1'b0;
            #1;
            chk("mrst_valid", 16'(u_if.tx_valid), 16'd0);
            chk("mrst_busy", 16'(busy), 16'd0);
            enable = 1'b0;
            in     = 16'h8000;
            step();
            step();
            reset         = 1'b1;
            u_if.tx_ready = 1'b1;
            enable        = 1'b1;
            wait_fs("mrst2", ok);
            if (ok) chk_frame("mrst2", vecs[4].b);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
